// File: rtl/rgb_frame_seq.sv
// rtl/rgb_frame_seq.sv - raster beat sequencer with ready/valid flow control for rgb_proc
// Optional completed-frame counter enabled by defining RGB_FRAME_SEQ_FRAME_CNT_EN.
module rgb_frame_seq #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [2:0]  switch_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        vde_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic [2:0]  switch_o,
  output logic [15:0] frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] X_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] Y_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic [11:0] w_x_nxt;
  logic [11:0] w_y_nxt;
  logic [2:0]  r_sw;
  logic [2:0]  w_sw_nxt;
  logic        r_valid;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;
  logic        w_accept;
  logic        w_last;
  logic        w_frame_done;
  logic        w_active_nxt;

  assign w_accept     = r_valid & ready_i;
  assign w_last       = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_frame_done = w_accept & w_last;
  assign w_active_nxt = (w_state_nxt != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_sw_nxt    = r_sw;

    case (r_state)
      ST_IDLE: begin
        if (en_i) begin
          w_state_nxt = ST_RUN;
          w_x_nxt     = 12'd0;
          w_y_nxt     = 12'd0;
          w_sw_nxt    = switch_i;
        end
      end
      ST_RUN: begin
        if (!en_i) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (en_i)              w_state_nxt = ST_RUN;
        else if (w_frame_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Counters only move on an accepted beat; the final wrap leaves (0,0) for IDLE.
    if (w_accept) begin
      if (r_x == X_LAST) begin
        w_x_nxt = 12'd0;
        w_y_nxt = (r_y == Y_LAST) ? 12'd0 : r_y + 12'd1;
      end else begin
        w_x_nxt = r_x + 12'd1;
      end
    end

    if (w_frame_done) w_sw_nxt = switch_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_x     <= 12'd0;
      r_y     <= 12'd0;
      r_sw    <= 3'd0;
      r_valid <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_de    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_sw    <= w_sw_nxt;
      r_valid <= w_active_nxt;
      r_de    <= w_active_nxt && (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
      r_hs    <= w_active_nxt && (w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END);
      r_vs    <= w_active_nxt && (w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END);
    end
  end

  assign valid_o  = r_valid;
  assign hsync_o  = r_hs;
  assign vsync_o  = r_vs;
  assign vde_o    = r_de;
  assign x_o      = r_x;
  assign y_o      = r_y;
  assign switch_o = r_sw;

`ifdef RGB_FRAME_SEQ_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)             r_frame_cnt <= 16'd0;
    else if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_cnt_o = r_frame_cnt;
`else
  assign frame_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_rgb_frame_seq.sv
// tb/tb_rgb_frame_seq.sv - directed vector bench for rgb_frame_seq on a 8x6 raster
module tb_rgb_frame_seq;

`ifdef RGB_FRAME_SEQ_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [2:0]  switch_i;
  logic        ready_i;
  logic        valid_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        vde_o;
  logic [11:0] x_o;
  logic [11:0] y_o;
  logic [2:0]  switch_o;
  logic [15:0] frame_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  logic        exp_valid;
  logic [11:0] exp_x;
  logic [11:0] exp_y;
  logic [2:0]  exp_sw;
  logic [15:0] exp_fc;
  logic        exp_stop;

  typedef struct {
    logic        en;
    logic        rdy;
    logic [2:0]  sw;
    logic        valid;
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        vs;
    logic        de;
  } vec_t;

  vec_t vecs[17];

  rgb_frame_seq #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .switch_i   (switch_i),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .vde_o      (vde_o),
    .x_o        (x_o),
    .y_o        (y_o),
    .switch_o   (switch_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(logic en, logic rdy, logic [2:0] sw, logic v,
                              int x, int y, logic hs, logic vs, logic de);
    vec_t r;
    r.en = en; r.rdy = rdy; r.sw = sw; r.valid = v;
    r.x = 12'(x); r.y = 12'(y); r.hs = hs; r.vs = vs; r.de = de;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic v, logic [11:0] x, logic [11:0] y,
                            logic hs, logic vs, logic de, logic [2:0] sw, logic [15:0] fc);
    chk({tag, ".valid"}, 32'(valid_o), 32'(v));
    chk({tag, ".x"}, 32'(x_o), 32'(x));
    chk({tag, ".y"}, 32'(y_o), 32'(y));
    chk({tag, ".hsync"}, 32'(hsync_o), 32'(hs));
    chk({tag, ".vsync"}, 32'(vsync_o), 32'(vs));
    chk({tag, ".vde"}, 32'(vde_o), 32'(de));
    chk({tag, ".switch"}, 32'(switch_o), 32'(sw));
    chk({tag, ".frame_cnt"}, 32'(frame_cnt_o), 32'(fc));
  endtask

  // One clock with the current inputs; expected timing comes from the raster geometry.
  task automatic step_chk(string tag);
    logic       acc;
    logic       last;
    logic [2:0] sw_at;
    logic       hs;
    logic       vs;
    logic       de;
    acc   = exp_valid && ready_i;
    last  = (exp_x == 12'd7) && (exp_y == 12'd5);
    sw_at = switch_i;
    @(posedge clk_i);
    if (acc) begin
      if (last) begin
        exp_sw = sw_at;
        if (FC_EN) exp_fc = exp_fc + 16'd1;
        if (exp_stop) exp_valid = 1'b0;
      end
      if (exp_x == 12'd7) begin
        exp_x = 12'd0;
        exp_y = (exp_y == 12'd5) ? 12'd0 : exp_y + 12'd1;
      end else begin
        exp_x = exp_x + 12'd1;
      end
    end
    #1;
    de = exp_valid && (exp_x < 12'd4) && (exp_y < 12'd3);
    hs = exp_valid && (exp_x >= 12'd5) && (exp_x < 12'd7);
    vs = exp_valid && (exp_y == 12'd4);
    check_outs(tag, exp_valid, exp_x, exp_y, hs, vs, de, exp_sw, exp_fc);
  endtask

  initial begin
    vecs[0]  = mk(1, 1, 3'b000, 1, 0, 0, 0, 0, 1);
    vecs[1]  = mk(1, 1, 3'b000, 1, 1, 0, 0, 0, 1);
    vecs[2]  = mk(1, 1, 3'b000, 1, 2, 0, 0, 0, 1);
    vecs[3]  = mk(1, 1, 3'b000, 1, 3, 0, 0, 0, 1);
    vecs[4]  = mk(1, 1, 3'b000, 1, 4, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 3'b000, 1, 5, 0, 1, 0, 0);
    vecs[6]  = mk(1, 1, 3'b000, 1, 6, 0, 1, 0, 0);
    vecs[7]  = mk(1, 1, 3'b000, 1, 7, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 3'b000, 1, 0, 1, 0, 0, 1);
    vecs[9]  = mk(1, 1, 3'b101, 1, 1, 1, 0, 0, 1);
    vecs[10] = mk(1, 1, 3'b101, 1, 2, 1, 0, 0, 1);
    for (int i = 11; i < 16; i++) vecs[i] = mk(1, 0, 3'b101, 1, 2, 1, 0, 0, 1);
    vecs[16] = mk(1, 1, 3'b101, 1, 3, 1, 0, 0, 1);

    rst_i = 1'b1; en_i = 1'b0; ready_i = 1'b1; switch_i = 3'b000;
    repeat (2) @(posedge clk_i);
    #1;
    check_outs("reset", 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);

    rst_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      en_i = vecs[i].en; ready_i = vecs[i].rdy; switch_i = vecs[i].sw;
      @(posedge clk_i);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].x, vecs[i].y,
                 vecs[i].hs, vecs[i].vs, vecs[i].de, 3'b000, 16'd0);
    end

    exp_valid = 1'b1; exp_x = 12'd3; exp_y = 12'd1;
    exp_sw = 3'b000; exp_fc = 16'd0; exp_stop = 1'b0;
    ready_i = 1'b1;

    for (int i = 0; i < 37; i++) step_chk("frame1");
    chk("switch_at_new_frame", 32'(switch_o), 32'(3'b101));

    for (int i = 0; i < 19; i++) step_chk("frame2");
    chk("at_3_2", 32'({x_o, y_o}), 32'({12'd3, 12'd2}));
    en_i = 1'b0;
    exp_stop = 1'b1;
    for (int i = 0; i < 28; i++) step_chk("stop_drain");
    chk("at_7_5", 32'({x_o, y_o}), 32'({12'd7, 12'd5}));
    step_chk("to_idle");
    chk("idle_valid", 32'(valid_o), 32'(0));
    exp_stop = 1'b0;
    for (int i = 0; i < 3; i++) step_chk("idle");

    switch_i = 3'b011;
    en_i = 1'b1;
    @(posedge clk_i);
    exp_valid = 1'b1; exp_x = 12'd0; exp_y = 12'd0; exp_sw = 3'b011;
    #1;
    check_outs("restart", 1'b1, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 3'b011, exp_fc);

    for (int i = 0; i < 48; i++) begin
      if (i == 10) en_i = 1'b0;
      if (i == 12) en_i = 1'b1;
      step_chk("frame3");
    end
    chk("frame_cnt_3", 32'(frame_cnt_o), FC_EN ? 32'd3 : 32'd0);

    for (int i = 0; i < 38; i++) step_chk("frame4");
    ready_i = 1'b0;
    step_chk("stall_6_4");
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_outs("reset_mid", 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0);
    exp_valid = 1'b0; exp_x = 12'd0; exp_y = 12'd0; exp_sw = 3'd0; exp_fc = 16'd0;

    rst_i = 1'b0; en_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step_chk("post_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_frame_seq.md
RGB_FRAME_SEQ -- requirements
Module: rgb_frame_seq

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch, sync and back porch in beats.
REQ-003 SHALL have parameters V_ACTIVE / V_FP / V_SYNC / V_BP, defaults 480 / 10 / 2 / 33, lines per region.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port en_i, input, 1 bit, run request.
REQ-007 SHALL have port switch_i, input, 3 bits, raw processing mode select.
REQ-008 SHALL have port ready_i, input, 1 bit, downstream (rgb_proc) ready.
REQ-009 SHALL have port valid_o, output, 1 bit, beat valid.
REQ-010 SHALL have ports hsync_o / vsync_o / vde_o, outputs, 1 bit each, active-high timing for the current beat.
REQ-011 SHALL have ports x_o / y_o, outputs, 12 bits each, current horizontal / vertical counter.
REQ-012 SHALL have port switch_o, output, 3 bits, frame-stable mode select for rgb_proc.
REQ-013 SHALL have port frame_cnt_o, output, 16 bits, completed-frame count.

Function
REQ-014 SHALL implement FSM IDLE, RUN, STOP; IDLE->RUN on en_i=1; RUN->STOP on en_i=0; STOP->RUN on en_i=1; STOP->IDLE when last beat of frame (x=H_TOTAL-1, y=V_TOTAL-1) accepted with en_i=0.
REQ-015 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise; one beat per (x,y).
REQ-016 SHALL drive valid_o=1 in RUN and STOP, 0 in IDLE; first beat (0,0) valid one cycle after en_i sampled high in IDLE.
REQ-017 SHALL accept a beat when valid_o=1 and ready_i=1; only then advance x, wrapping H_TOTAL-1->0 and incrementing y, y wrapping V_TOTAL-1->0.
REQ-018 SHALL hold x_o, y_o, hsync_o, vsync_o, vde_o, switch_o stable while valid_o=1 and ready_i=0.
REQ-019 SHALL assert vde_o iff x<H_ACTIVE and y<V_ACTIVE; hsync_o iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; vsync_o iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; all three 0 in IDLE.
REQ-020 SHALL load switch_o from switch_i on IDLE->RUN and on every acceptance of beat (H_TOTAL-1,V_TOTAL-1); never mid-frame.
REQ-021 SHALL, in IDLE, hold x_o=y_o=0.
REQ-022 SHALL give en_i toggles mid-frame no effect on counters; STOP->RUN causes no gap beat.
REQ-023 SHALL register all outputs; no combinational path from ready_i or en_i to any output.

Reset
REQ-024 SHALL on rst_i=1 at a clock edge enter IDLE and force valid_o, hsync_o, vsync_o, vde_o=0, x_o=y_o=0, switch_o=0, frame_cnt_o=0, including mid-frame and under stall.
REQ-025 SHALL after reset release restart at (0,0) only via REQ-014.

Configuration
REQ-026 SHALL with macro RGB_FRAME_SEQ_FRAME_CNT_EN defined increment frame_cnt_o (modulo 2^16) on each acceptance of beat (H_TOTAL-1,V_TOTAL-1).
REQ-027 SHALL without RGB_FRAME_SEQ_FRAME_CNT_EN keep port frame_cnt_o, tied to 0, no counter logic.

Verification (H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=3,V_FP=1,V_SYNC=1,V_BP=1; 48 beats/frame)
REQ-028 SHALL cover: reset, en_i=1, ready_i=1 -> valid_o next cycle, x cycles 0..7, vde_o on x=0..3 for y=0..2, hsync_o on x=5,6, vsync_o on y=4.
REQ-029 SHALL cover: ready_i=0 for 5 cycles at (x=2,y=1) -> all outputs frozen at (2,1), vde_o=1; resume -> next beat (3,1).
REQ-030 SHALL cover: switch_i 3'b000->3'b101 at beat (1,1) -> switch_o stays 000 until beat (0,0) of next frame, then 101.
REQ-031 SHALL cover: en_i=0 at beat (3,2) -> beats continue to (7,5), valid_o=0 next cycle, FSM IDLE.
REQ-032 SHALL cover: rst_i=1 at (6,4) with ready_i=0 -> next cycle valid_o=0, x_o=y_o=0, switch_o=0.
REQ-033 SHALL cover: macro defined, 3 full frames -> frame_cnt_o=3; macro undefined -> frame_cnt_o=0 throughout.
